// File: rtl/pipe_gen.sv
// pipe_gen: 16x16 scrolling pipe field with a gap generator, spawn/score pulses and a run/halt FSM.
// Optional score counter enabled by defining PIPE_SCORE_CNT_EN (revision 1.0).
`default_nettype none

module pipe_gen #(
  parameter int GAP      = 4,
  parameter int SPACING  = 6,
  parameter int BIRD_COL = 3
) (
  input  logic        Clock,
  input  logic        RST,
  input  logic        tick,
  input  logic [9:0]  rnd,
  input  logic        start,
  input  logic        crash,
  input  logic [3:0]  col_sel,
  input  logic [3:0]  bird_row,
  output logic [15:0] col_data,
  output logic        hit,
  output logic [1:0]  state,
  output logic        spawn,
  output logic        score_pulse,
  output logic [7:0]  score
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } state_e;

  localparam logic [3:0] CNT_MAX  = 4'(SPACING - 1);
  localparam logic [4:0] TOP_SPAN = 5'(15 - GAP);

  state_e             state_q, state_d;
  logic [15:0][15:0]  field_q, field_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               spawn_q, spawn_d;
  logic               score_pulse_q, score_pulse_d;
  logic [4:0]         gap_top;
  logic [15:0]        pipe_col;
  logic               unused_rnd;

  assign unused_rnd = ^rnd[9:4];

  // Gap top row folds the upper random range back so the gap always fits.
  always_comb begin
    gap_top  = {1'b0, rnd[3:0]};
    pipe_col = '1;
    if (rnd[3:0] == 4'd0) begin
      gap_top = 5'd1;
    end else if ({1'b0, rnd[3:0]} > TOP_SPAN) begin
      gap_top = {1'b0, rnd[3:0]} - TOP_SPAN;
    end
    for (int i = 0; i < 16; i++) begin
      if ((i >= int'(gap_top)) && (i < int'(gap_top) + GAP)) begin
        pipe_col[i] = 1'b0;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    field_d       = field_q;
    cnt_d         = cnt_q;
    spawn_d       = 1'b0;
    score_pulse_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          field_d = '0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (crash) begin
          state_d = HALT;
        end else if (tick) begin
          field_d[14:0] = field_q[15:1];
          field_d[15]   = (cnt_q == 4'd0) ? pipe_col : 16'h0000;
          cnt_d         = (cnt_q == CNT_MAX) ? 4'd0 : cnt_q + 4'd1;
          spawn_d       = (cnt_q == 4'd0);
          score_pulse_d = (field_q[BIRD_COL] != 16'h0000);
        end
      end
      HALT: begin
        if (start) begin
          state_d = RUN;
          field_d = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (RST) begin
      state_q       <= IDLE;
      field_q       <= '0;
      cnt_q         <= '0;
      spawn_q       <= 1'b0;
      score_pulse_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      field_q       <= field_d;
      cnt_q         <= cnt_d;
      spawn_q       <= spawn_d;
      score_pulse_q <= score_pulse_d;
    end
  end

`ifdef PIPE_SCORE_CNT_EN
  logic       start_accept;
  logic [7:0] score_q, score_d;

  assign start_accept = start && (state_q != RUN);

  always_comb begin
    score_d = score_q;
    if (start_accept) begin
      score_d = 8'h00;
    end else if (score_pulse_q && (score_q != 8'hFF)) begin
      score_d = score_q + 8'd1;
    end
  end

  always_ff @(posedge Clock) begin
    if (RST) begin
      score_q <= 8'h00;
    end else begin
      score_q <= score_d;
    end
  end

  assign score = score_q;
`else
  assign score = 8'h00;
`endif

  assign col_data    = field_q[col_sel];
  assign hit         = field_q[BIRD_COL][bird_row];
  assign state       = state_q;
  assign spawn       = spawn_q;
  assign score_pulse = score_pulse_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_gen.sv
// tb_pipe_gen: directed and random stimulus for pipe_gen checked against a column-list reference model.
`default_nettype none
`timescale 1ns/1ps

module tb_pipe_gen;

  localparam int GAP      = 4;
  localparam int SPACING  = 6;
  localparam int BIRD_COL = 3;

  logic        Clock = 1'b0;
  logic        RST = 1'b0;
  logic        tick = 1'b0;
  logic [9:0]  rnd = '0;
  logic        start = 1'b0;
  logic        crash = 1'b0;
  logic [3:0]  col_sel = '0;
  logic [3:0]  bird_row = '0;
  logic [15:0] col_data;
  logic        hit;
  logic [1:0]  state;
  logic        spawn;
  logic        score_pulse;
  logic [7:0]  score;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: game mode, list of columns, spawn countdown, pulses, score.
  int          m_mode = 0;
  logic [15:0] m_col[16];
  int          m_cnt = 0;
  bit          m_spawn = 0;
  bit          m_sp = 0;
  int          m_score = 0;

  pipe_gen #(.GAP(GAP), .SPACING(SPACING), .BIRD_COL(BIRD_COL)) dut (
    .Clock(Clock), .RST(RST), .tick(tick), .rnd(rnd), .start(start), .crash(crash),
    .col_sel(col_sel), .bird_row(bird_row), .col_data(col_data), .hit(hit),
    .state(state), .spawn(spawn), .score_pulse(score_pulse), .score(score)
  );

  always #20 Clock = ~Clock;

  function automatic logic [15:0] pipe_of(input logic [9:0] r_in);
    int r, top;
    logic [31:0] gap_mask;
    r = int'(r_in[3:0]);
    if (r == 0) top = 1;
    else if (r > 15 - GAP) top = r - (15 - GAP);
    else top = r;
    gap_mask = ((32'd1 << GAP) - 32'd1) << top;
    return ~gap_mask[15:0];
  endfunction

  task automatic clear_field();
    for (int i = 0; i < 16; i++) m_col[i] = 16'h0000;
  endtask

  task automatic model_update(input bit t, input bit s, input bit c, input bit r, input logic [9:0] rv);
    bit old_sp;
    old_sp = m_sp;
    if (r) begin
      m_mode = 0; clear_field(); m_cnt = 0; m_spawn = 0; m_sp = 0; m_score = 0;
      return;
    end
    m_spawn = 0;
    m_sp    = 0;
`ifdef PIPE_SCORE_CNT_EN
    if (old_sp && m_score < 255) m_score = m_score + 1;
`endif
    if (m_mode == 1) begin
      if (c) begin
        m_mode = 2;
      end else if (t) begin
        m_sp = (m_col[BIRD_COL] != 16'h0000);
        for (int i = 0; i < 15; i++) m_col[i] = m_col[i + 1];
        m_col[15] = (m_cnt == 0) ? pipe_of(rv) : 16'h0000;
        m_spawn = (m_cnt == 0);
        m_cnt = (m_cnt + 1) % SPACING;
      end
    end else if (s) begin
      m_mode = 1; clear_field(); m_cnt = 0; m_score = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [255:0] obs_f, exp_f;
    for (int c = 0; c < 16; c++) begin
      col_sel = 4'(c);
      #1;
      obs_f[c*16 +: 16] = col_data;
      exp_f[c*16 +: 16] = m_col[c];
    end
    chk("field", obs_f, exp_f);
    bird_row = 4'($urandom);
    #1;
    chk("hit", 256'(hit), 256'(m_col[BIRD_COL][bird_row]));
    chk("state", 256'(state), 256'(m_mode));
    chk("spawn", 256'(spawn), 256'(m_spawn));
    chk("score_pulse", 256'(score_pulse), 256'(m_sp));
    chk("score", 256'(score), 256'(m_score));
  endtask

  task automatic step(input bit t, input bit s, input bit c, input bit r, input logic [9:0] rv);
    tick = t; start = s; crash = c; RST = r; rnd = rv;
    @(posedge Clock);
    model_update(t, s, c, r, rv);
    #1;
    check_all();
    tick = 0; start = 0; crash = 0; RST = 0;
  endtask

  initial begin
    clear_field();

    // Reset
    step(0, 0, 0, 1, 10'h000);
    chk("rst_state", 256'(state), 256'(2'b00));

    // First spawn with rnd=5
    step(0, 1, 0, 0, 10'h000);
    step(1, 0, 0, 0, 10'h005);
    chk("first_spawn", 256'(spawn), 256'(1'b1));
    col_sel = 4'd15; #1;
    chk("col15_rnd5", 256'(col_data), 256'(16'hFE1F));

    // Gap map edge values
    step(0, 0, 1, 0, 10'h000);
    step(0, 1, 0, 0, 10'h000);
    step(1, 0, 0, 0, 10'h000);
    col_sel = 4'd15; #1;
    chk("col15_rnd0", 256'(col_data), 256'(16'hFFE1));
    step(0, 0, 1, 0, 10'h000);
    step(0, 1, 0, 0, 10'h000);
    step(1, 0, 0, 0, 10'h00D);
    col_sel = 4'd15; #1;
    chk("col15_rnd13", 256'(col_data), 256'(16'hFFC3));

    // 14 back-to-back ticks: spawns after 1, 7, 13; first score pulse after 14
    step(0, 0, 1, 0, 10'h000);
    step(0, 1, 0, 0, 10'h000);
    for (int k = 1; k <= 14; k++) begin
      step(1, 0, 0, 0, 10'($urandom));
      chk($sformatf("spawn_t%0d", k), 256'(spawn), 256'((k == 1) || (k == 7) || (k == 13)));
      chk($sformatf("pulse_t%0d", k), 256'(score_pulse), 256'(k == 14));
    end
    step(0, 0, 0, 0, 10'h000);
`ifdef PIPE_SCORE_CNT_EN
    chk("score_after14", 256'(score), 256'(8'd1));
`else
    chk("score_after14", 256'(score), 256'(8'd0));
`endif

    // Crash with tick freezes; start with crash in HALT restarts
    step(1, 0, 1, 0, 10'h003);
    chk("crash_state", 256'(state), 256'(2'b10));
    step(1, 0, 0, 0, 10'h003);
    step(0, 1, 1, 0, 10'h000);
    chk("restart_state", 256'(state), 256'(2'b01));

    // Reset mid-run, then restart
    for (int k = 0; k < 5; k++) step(1, 0, 0, 0, 10'($urandom));
    step(1, 1, 1, 1, 10'h000);
    chk("midrun_rst_state", 256'(state), 256'(2'b00));
    step(0, 1, 0, 0, 10'h000);
    step(1, 0, 0, 0, 10'h009);
    chk("post_rst_spawn", 256'(spawn), 256'(1'b1));

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      step(bit'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 29) == 0), ($urandom_range(0, 79) == 0), 10'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
